dft_outbuf: RTL and testbench
=============================

DFT_OUTBUF -- requirements
Module: dft_outbuf

Interface
REQ-001 SHALL have parameter DATA_W, default 15: width of input magnitude samples and m_data.
REQ-002 SHALL have parameter FRAME_LEN, default 256: samples per frame; power of two, 4 to 1024; IDX_W = clog2(FRAME_LEN).
REQ-003 SHALL have port clk, input, 1: the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-low reset (rst=0 resets on the clk edge).
REQ-005 SHALL have port data_in, input, DATA_W: unsigned averaged-magnitude sample from the DFT stage.
REQ-006 SHALL have port valid_in, input, 1: data_in valid this cycle; no backpressure toward the source.
REQ-007 SHALL have port m_data, output, DATA_W: streamed sample.
REQ-008 SHALL have port m_index, output, IDX_W: position of m_data within its frame.
REQ-009 SHALL have port m_last, output, 1: high with the sample at index FRAME_LEN-1.
REQ-010 SHALL have port m_valid, output, 1: m_data, m_index and m_last are valid.
REQ-011 SHALL have port m_ready, input, 1: consumer accepts the word; transfer when m_valid and m_ready are both high.
REQ-012 SHALL have port ovf_clr, input, 1: single-cycle clear of overflow.
REQ-013 SHALL have port overflow, output, 1: sticky; set when at least one frame has been dropped.
REQ-014 SHALL have port drop_cnt, output, 8: count of dropped frames, saturating at 255.

Function
REQ-015 SHALL contain two banks of FRAME_LEN x DATA_W (ping-pong), a write-bank pointer wbank, a read-bank pointer rbank, and per-bank flags full[1:0].
REQ-016 SHALL use a write counter wr_ptr that advances on every valid_in and wraps from FRAME_LEN-1 to 0.
REQ-017 SHALL make the accept/drop decision on the valid_in at wr_ptr==0, using the registered full[wbank]: full=0 accepts the frame; full=1 drops the whole frame.
REQ-018 SHALL, for an accepted frame, write data_in to bank[wbank][wr_ptr]; on the valid_in at wr_ptr==FRAME_LEN-1 it SHALL set full[wbank] and toggle wbank.
REQ-019 SHALL, for a dropped frame, still advance wr_ptr with no RAM writes; at its final sample it SHALL set overflow, increment drop_cnt (saturating), and leave wbank and full unchanged.
REQ-020 SHALL run the read FSM with states IDLE, FETCH and STREAM.
REQ-021 SHALL move IDLE->FETCH when full[rbank]=1, with rd_ptr=0.
REQ-022 SHALL, in FETCH, issue a synchronous RAM read (1-cycle latency) and go to STREAM with m_valid=1 on the following cycle.
REQ-023 SHALL, in STREAM, hold all m_* stable while m_valid=1 and m_ready=0.
REQ-024 SHALL, in STREAM on a transfer, present the next word the very next cycle (prefetch/skid), sustaining 1 word per clk while m_ready stays high.
REQ-025 SHALL, on the transfer with m_last=1, clear full[rbank], toggle rbank and return to IDLE; m_valid=0 for at least that next cycle.
REQ-026 SHALL give first-word latency of 3 clk from the valid_in that completes a frame (bank idle) to m_valid=1.
REQ-027 SHALL apply both updates when a full-set by the write side and a full-clear by the read side hit different banks in the same cycle.
REQ-028 SHALL drop the frame when a clear of the same bank coincides with the wr_ptr==0 decision, because the decision uses the pre-clear value.
REQ-029 SHALL give set priority when ovf_clr coincides with an overflow event: overflow=1 and drop_cnt counts the event.
REQ-030 SHALL clear overflow and zero drop_cnt on ovf_clr.

Reset
REQ-031 SHALL, with rst=0, force: wr_ptr=0, rd_ptr=0, wbank=0, rbank=0, full=00, FSM=IDLE, m_valid=0, m_last=0, m_data=0, m_index=0, overflow=0, drop_cnt=0.
REQ-032 SHALL discard a partially written or partially streamed frame when reset is applied mid-operation; RAM contents are not cleared.

Configuration
REQ-033 SHALL, with macro DFT_OUTBUF_PEAK_EN defined, add outputs peak_value (DATA_W), peak_index (IDX_W) and peak_valid (1).
REQ-034 SHALL, with DFT_OUTBUF_PEAK_EN defined, track the per-frame maximum over accepted frames, with ties resolved to the lowest index.
REQ-035 SHALL, with DFT_OUTBUF_PEAK_EN defined, update peak_value/peak_index and pulse peak_valid for 1 clk on the cycle after the final sample of an accepted frame.
REQ-036 SHALL, with DFT_OUTBUF_PEAK_EN defined, reset all peak outputs to 0.
REQ-037 SHALL, without DFT_OUTBUF_PEAK_EN, omit the peak ports and all peak logic.

Verification
REQ-038 SHALL cover: 256 samples data_in=i, m_ready=1 -> m_data 0..255 contiguous, m_index=data, m_last only at 255, first m_valid 3 clk after the last input.
REQ-039 SHALL cover: m_ready toggling 1/0 every cycle -> every word delivered exactly once, in order, stable while stalled.
REQ-040 SHALL cover: 3 frames back-to-back, m_ready=0 -> frames 1-2 buffered, frame 3 dropped; overflow=1, drop_cnt=1; after m_ready=1, frames 1 then 2 out intact.
REQ-041 SHALL cover: ovf_clr in the same cycle as a drop event -> overflow stays 1 and drop_cnt increments; ovf_clr alone later -> overflow=0, drop_cnt=0.
REQ-042 SHALL cover: rst=0 for 1 clk during input sample 100 -> all outputs at reset values; the next 256 samples form a clean frame starting at m_index 0.
REQ-043 SHALL cover, with DFT_OUTBUF_PEAK_EN: frame with value 5000 at indices 17 and 200 -> peak_value=5000, peak_index=17, single peak_valid pulse.

Source files
------------

// File: rtl/dft_outbuf.sv
// dft_outbuf: ping-pong frame buffer between the DFT magnitude stage and a
// ready/valid consumer. Frames are written at the source rate with no
// backpressure; a frame that finds its bank still occupied is dropped whole
// and recorded in a sticky overflow flag and a saturating drop counter.
// Optional feature: define DFT_OUTBUF_PEAK_EN to add per-frame peak tracking
// (peak_value / peak_index / peak_valid).
module dft_outbuf #(
    parameter int DATA_W    = 15,
    parameter int FRAME_LEN = 256,
    localparam int IDX_W    = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic [DATA_W-1:0] m_data,
    output logic [IDX_W-1:0]  m_index,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic              ovf_clr,
    output logic              overflow,
    output logic [7:0]        drop_cnt
`ifdef DFT_OUTBUF_PEAK_EN
    ,
    output logic [DATA_W-1:0] peak_value,
    output logic [IDX_W-1:0]  peak_index,
    output logic              peak_valid
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_STREAM = 2'd2
    } rd_state_e;

    // Both banks share one array; the bank bit is the address MSB.
    logic [DATA_W-1:0] mem_q [0:2*FRAME_LEN-1];

    // Write side
    logic [IDX_W-1:0]  wr_ptr_q;
    logic              wbank_q;
    logic              accept_q;
    logic              frame_acc_s;
    logic              wr_en_s;
    logic              frame_done_s;
    logic              full_set_s;
    logic              ovf_evt_s;

    // Bank occupancy
    logic [1:0]        full_q;
    logic [1:0]        full_d;
    logic [1:0]        set_mask_s;
    logic [1:0]        clr_mask_s;

    // Read side
    rd_state_e         state_q;
    rd_state_e         state_d;
    logic [IDX_W-1:0]  rd_ptr_q;
    logic [IDX_W-1:0]  rd_ptr_d;
    logic [IDX_W-1:0]  rd_next_s;
    logic              rbank_q;
    logic              rbank_d;
    logic              m_valid_q;
    logic              m_valid_d;
    logic              m_last_q;
    logic              m_last_d;
    logic              rd_en_s;
    logic [IDX_W-1:0]  raddr_s;
    logic              rd_done_s;
    logic              xfer_s;
    logic [DATA_W-1:0] rdata_q;

    // Status
    logic              overflow_q;
    logic [7:0]        drop_cnt_q;

    assign xfer_s    = m_valid_q & m_ready;
    assign rd_next_s = rd_ptr_q + ONE_IDX;

    // Accept/drop decision: taken at the first sample of a frame from the registered bank flag, then held for the frame.
    always_comb begin
        if (wr_ptr_q == '0) begin
            frame_acc_s = ~full_q[wbank_q];
        end else begin
            frame_acc_s = accept_q;
        end
        wr_en_s      = valid_in & frame_acc_s;
        frame_done_s = valid_in & (wr_ptr_q == LAST_IDX);
        full_set_s   = frame_done_s & frame_acc_s;
        ovf_evt_s    = frame_done_s & ~frame_acc_s;
    end

    // Write pointer, bank pointer and held accept decision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            wbank_q  <= 1'b0;
            accept_q <= 1'b0;
        end else if (valid_in) begin
            wr_ptr_q <= wr_ptr_q + ONE_IDX;
            if (wr_ptr_q == '0) begin
                accept_q <= frame_acc_s;
            end
            if (full_set_s) begin
                wbank_q <= ~wbank_q;
            end
        end
    end

    // Sample storage; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[{wbank_q, wr_ptr_q}] <= data_in;
        end
    end

    // Bank flags: a write-side set and a read-side clear on different banks both apply.
    always_comb begin
        set_mask_s = full_set_s ? (wbank_q ? 2'b10 : 2'b01) : 2'b00;
        clr_mask_s = rd_done_s  ? (rbank_q ? 2'b10 : 2'b01) : 2'b00;
        full_d     = (full_q & ~clr_mask_s) | set_mask_s;
    end

    // Bank flag register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full_q <= 2'b00;
        end else begin
            full_q <= full_d;
        end
    end

    // Overflow bookkeeping: a drop event wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else if (ovf_evt_s) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end
    end

    // Read FSM next state: the RAM is read one cycle ahead so a transfer is followed by the next word immediately.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        rbank_d   = rbank_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        rd_en_s   = 1'b0;
        raddr_s   = rd_ptr_q;
        rd_done_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_q[rbank_q]) begin
                    state_d  = ST_FETCH;
                    rd_ptr_d = '0;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_FETCH: begin
                rd_en_s   = 1'b1;
                raddr_s   = '0;
                state_d   = ST_STREAM;
                m_valid_d = 1'b1;
                m_last_d  = 1'b0;
            end
            ST_STREAM: begin
                if (xfer_s) begin
                    if (m_last_q) begin
                        rd_done_s = 1'b1;
                        rbank_d   = ~rbank_q;
                        state_d   = ST_IDLE;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                    end else begin
                        rd_en_s   = 1'b1;
                        raddr_s   = rd_next_s;
                        rd_ptr_d  = rd_next_s;
                        m_last_d  = (rd_next_s == LAST_IDX);
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
            end
        endcase
    end

    // Read FSM and output-qualifier registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rd_ptr_q  <= '0;
            rbank_q   <= 1'b0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            rbank_q   <= rbank_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
        end
    end

    // RAM read register; only loads on a read so the word holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (rd_en_s) begin
            rdata_q <= mem_q[{rbank_q, raddr_s}];
        end
    end

    assign m_data   = rdata_q;
    assign m_index  = rd_ptr_q;
    assign m_last   = m_last_q;
    assign m_valid  = m_valid_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

`ifdef DFT_OUTBUF_PEAK_EN
    logic [DATA_W-1:0] run_max_q;
    logic [IDX_W-1:0]  run_idx_q;
    logic [DATA_W-1:0] peak_value_q;
    logic [IDX_W-1:0]  peak_index_q;
    logic              peak_valid_q;
    logic              is_new_s;
    logic [DATA_W-1:0] cand_val_s;
    logic [IDX_W-1:0]  cand_idx_s;

    // Running maximum candidate; strict compare keeps the lowest index on ties.
    always_comb begin
        is_new_s   = (wr_ptr_q == '0) || (data_in > run_max_q);
        cand_val_s = is_new_s ? data_in  : run_max_q;
        cand_idx_s = is_new_s ? wr_ptr_q : run_idx_q;
    end

    // Peak tracking over accepted frames, published the cycle after the final sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            run_max_q    <= '0;
            run_idx_q    <= '0;
            peak_value_q <= '0;
            peak_index_q <= '0;
            peak_valid_q <= 1'b0;
        end else begin
            peak_valid_q <= 1'b0;
            if (wr_en_s) begin
                run_max_q <= cand_val_s;
                run_idx_q <= cand_idx_s;
                if (full_set_s) begin
                    peak_value_q <= cand_val_s;
                    peak_index_q <= cand_idx_s;
                    peak_valid_q <= 1'b1;
                end
            end
        end
    end

    assign peak_value = peak_value_q;
    assign peak_index = peak_index_q;
    assign peak_valid = peak_valid_q;
`endif

endmodule

// File: tb/tb_dft_outbuf.sv
// Self-checking bench for dft_outbuf with a scoreboard of expected output words.
module tb_dft_outbuf;

    localparam int DW = 15;
    localparam int IW = 8;
    localparam int FL = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic [DW-1:0] m_data;
    logic [IW-1:0] m_index;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;
    logic          ovf_clr;
    logic          overflow;
    logic [7:0]    drop_cnt;
`ifdef DFT_OUTBUF_PEAK_EN
    logic [DW-1:0] peak_value;
    logic [IW-1:0] peak_index;
    logic          peak_valid;
    int            peak_pulses = 0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [DW+IW:0] exp_q[$];
    logic [DW+IW:0] exp_w;

    logic          tog_en = 1'b0;
    logic          prev_stall = 1'b0;
    logic          post_last = 1'b0;
    logic [DW-1:0] prev_data;
    logic [IW-1:0] prev_index;
    logic          prev_last;
    int            lat;

    dft_outbuf #(.DATA_W(DW), .FRAME_LEN(FL)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .valid_in (valid_in),
        .m_data   (m_data),
        .m_index  (m_index),
        .m_last   (m_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .ovf_clr  (ovf_clr),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
`ifdef DFT_OUTBUF_PEAK_EN
        ,
        .peak_value (peak_value),
        .peak_index (peak_index),
        .peak_valid (peak_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; inputs change #1 after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (tog_en) m_ready = ~m_ready;
    endtask

    task automatic send(input logic [DW-1:0] d);
        step();
        data_in  = d;
        valid_in = 1'b1;
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input int idx);
        exp_q.push_back({(idx == FL-1) ? 1'b1 : 1'b0, IW'(idx), d});
    endtask

    task automatic idle_input();
        step();
        valid_in = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) step();
        @(negedge clk);
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_m_valid"},  32'(m_valid),  32'd0);
        check_eq({tag, "_m_last"},   32'(m_last),   32'd0);
        check_eq({tag, "_m_data"},   32'(m_data),   32'd0);
        check_eq({tag, "_m_index"},  32'(m_index),  32'd0);
        check_eq({tag, "_overflow"}, 32'(overflow), 32'd0);
        check_eq({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
`ifdef DFT_OUTBUF_PEAK_EN
        check_eq({tag, "_peak_value"}, 32'(peak_value), 32'd0);
        check_eq({tag, "_peak_index"}, 32'(peak_index), 32'd0);
        check_eq({tag, "_peak_valid"}, 32'(peak_valid), 32'd0);
`endif
    endtask

    // Output monitor: scoreboard compare on transfers, stability while stalled, gap after last.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            prev_stall = 1'b0;
            post_last  = 1'b0;
        end else begin
            if (post_last) begin
                check_eq("gap_after_last", 32'(m_valid), 32'd0);
            end
            if (prev_stall) begin
                check_eq("hold_valid", 32'(m_valid), 32'd1);
                check_eq("hold_data",  32'(m_data),  32'(prev_data));
                check_eq("hold_index", 32'(m_index), 32'(prev_index));
                check_eq("hold_last",  32'(m_last),  32'(prev_last));
            end
            post_last = 1'b0;
            if (m_valid && m_ready) begin
                check_eq("sb_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    check_eq("sb_data",  32'(m_data),  32'(exp_w[DW-1:0]));
                    check_eq("sb_index", 32'(m_index), 32'(exp_w[DW+IW-1:DW]));
                    check_eq("sb_last",  32'(m_last),  32'(exp_w[DW+IW]));
                end
                post_last = m_last;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_index = m_index;
            prev_last  = m_last;
`ifdef DFT_OUTBUF_PEAK_EN
            if (peak_valid) peak_pulses++;
`endif
        end
    end

    initial begin
        rst      = 1'b0;
        data_in  = '0;
        valid_in = 1'b0;
        m_ready  = 1'b0;
        ovf_clr  = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check_reset_outputs("reset");
        step();
        rst = 1'b1;

        // Ramp frame with free-flowing consumer, plus first-word latency.
        m_ready = 1'b1;
        for (int i = 0; i < FL; i++) begin
            push_exp(DW'(i), i);
            send(DW'(i));
        end
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            idle_input();
            @(negedge clk);
            if (m_valid) begin
                lat = c;
                break;
            end
        end
        check_eq("first_word_latency", 32'(lat), 32'd3);
        wait_drain("drain_ramp", 1000);

        // Consumer ready toggling every cycle.
        tog_en = 1'b1;
        for (int i = 0; i < FL; i++) begin
            push_exp(DW'(i * 3 + 7), i);
            send(DW'(i * 3 + 7));
        end
        idle_input();
        wait_drain("drain_toggle", 2000);
        tog_en  = 1'b0;
        m_ready = 1'b1;

        // Three back-to-back frames against a stalled consumer: third dropped.
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 3 * FL; i++) begin
            if (i < 2 * FL) push_exp(DW'(1000 * (i / FL + 1) + i % FL), i % FL);
            send(DW'(1000 * (i / FL + 1) + i % FL));
            if (i == 2 * FL) begin
                @(negedge clk);
                check_eq("no_ovf_before_drop", 32'(overflow), 32'd0);
            end
        end
        idle_input();
        @(negedge clk);
        check_eq("drop_overflow", 32'(overflow), 32'd1);
        check_eq("drop_cnt_1",    32'(drop_cnt), 32'd1);
        step();
        m_ready = 1'b1;
        wait_drain("drain_two_frames", 2000);

        // Plain clear.
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        @(negedge clk);
        check_eq("clr_overflow", 32'(overflow), 32'd0);
        check_eq("clr_drop_cnt", 32'(drop_cnt), 32'd0);

        // Clear coinciding with a drop event: the event wins.
        m_ready = 1'b0;
        for (int i = 0; i < 3 * FL; i++) begin
            if (i < 2 * FL) push_exp(DW'(4000 * (i / FL + 1) + i % FL), i % FL);
            send(DW'(4000 * (i / FL + 1) + i % FL));
            ovf_clr = (i == 3 * FL - 1) ? 1'b1 : 1'b0;
        end
        idle_input();
        ovf_clr = 1'b0;
        @(negedge clk);
        check_eq("clr_vs_drop_overflow", 32'(overflow), 32'd1);
        check_eq("clr_vs_drop_cnt",      32'(drop_cnt), 32'd1);
        step();
        m_ready = 1'b1;
        wait_drain("drain_clr_frames", 2000);
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        @(negedge clk);
        check_eq("late_clr_overflow", 32'(overflow), 32'd0);
        check_eq("late_clr_drop_cnt", 32'(drop_cnt), 32'd0);

        // Reset pulse during input sample 100, then a clean frame.
        for (int i = 0; i < 100; i++) send(DW'(i));
        send(DW'(100));
        rst = 1'b0;
        step();
        rst      = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        for (int i = 0; i < FL; i++) begin
            push_exp(DW'(700 + i), i);
            send(DW'(700 + i));
        end
        idle_input();
        wait_drain("drain_after_reset", 1000);

`ifdef DFT_OUTBUF_PEAK_EN
        // Peak with a tie at indices 17 and 200.
        peak_pulses = 0;
        for (int i = 0; i < FL; i++) begin
            push_exp((i == 17 || i == 200) ? DW'(5000) : DW'(i), i);
            send((i == 17 || i == 200) ? DW'(5000) : DW'(i));
        end
        idle_input();
        @(negedge clk);
        check_eq("peak_valid_pulse", 32'(peak_valid), 32'd1);
        check_eq("peak_value", 32'(peak_value), 32'd5000);
        check_eq("peak_index", 32'(peak_index), 32'd17);
        wait_drain("drain_peak", 1000);
        check_eq("peak_pulse_count", 32'(peak_pulses), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
